// File: rtl/wb_arbiter_rr.sv
// Two-master round-robin arbiter in front of one Wishbone-classic slave port.
// A per-transaction watchdog completes the cycle itself if the slave stays silent.
module wb_arbiter_rr #(
  parameter int              ADR_W   = 16,
  parameter int              DAT_W   = 32,
  parameter int              TIMEOUT = 255,
  parameter logic [DAT_W-1:0] TO_DATA = 32'hDEAD_BEEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m0_stb,
  input  logic             m0_we,
  input  logic [ADR_W-1:0] m0_adr,
  input  logic [DAT_W-1:0] m0_dat_c,
  output logic [DAT_W-1:0] m0_dat_p,
  output logic             m0_ack,
  input  logic             m1_stb,
  input  logic             m1_we,
  input  logic [ADR_W-1:0] m1_adr,
  input  logic [DAT_W-1:0] m1_dat_c,
  output logic [DAT_W-1:0] m1_dat_p,
  output logic             m1_ack,
  output logic             s_stb,
  output logic             s_we,
  output logic [ADR_W-1:0] s_adr,
  output logic [DAT_W-1:0] s_dat_c,
  input  logic [DAT_W-1:0] s_dat_p,
  input  logic             s_ack,
  output logic             timeout
);

  localparam int WDOG_W = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              timeout_q, timeout_d;

  logic sel_stb;
  logic expire;
  logic to_fire;

  assign sel_stb = grant_q ? m1_stb : m0_stb;
  assign expire  = (wdog_q == WDOG_W'(TIMEOUT - 1));

  // Request fields are passed through unregistered; masters hold them stable while stb is high.
  assign s_we    = grant_q ? m1_we    : m0_we;
  assign s_adr   = grant_q ? m1_adr   : m0_adr;
  assign s_dat_c = grant_q ? m1_dat_c : m0_dat_c;

  assign m0_dat_p = (to_fire && !grant_q) ? TO_DATA : s_dat_p;
  assign m1_dat_p = (to_fire &&  grant_q) ? TO_DATA : s_dat_p;
  assign timeout  = timeout_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    s_stb     = 1'b0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    to_fire   = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_stb || m1_stb) begin
          grant_d = (m0_stb && m1_stb) ? ~last_q : m1_stb;
          state_d = BUSY;
          wdog_d  = '0;
        end
      end
      BUSY: begin
        if (s_ack) begin
          s_stb   = sel_stb;
          m0_ack  = !grant_q;
          m1_ack  = grant_q;
          state_d = IDLE;
          last_d  = grant_q;
        end else if (!sel_stb) begin
          // Master withdrew its request: drop the cycle silently.
          state_d = IDLE;
          last_d  = grant_q;
        end else if (expire) begin
          to_fire   = 1'b1;
          m0_ack    = !grant_q;
          m1_ack    = grant_q;
          timeout_d = 1'b1;
          state_d   = IDLE;
          last_d    = grant_q;
        end else begin
          s_stb  = 1'b1;
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

endmodule
